// File: rtl/iq_jump_pkg.sv
// Shared field offsets, FSM encoding and operand-readiness helper for the jump issue queue.
// Latency: none (types/constants only).
// Backpressure: n/a.
package iq_jump_pkg;

    localparam int DEC_W     = 72;  // decoded instruction bus, bits 71:0
    localparam int IQ_RS1_HI = 49;
    localparam int IQ_RS1_LO = 45;
    localparam int IQ_RS2_HI = 44;
    localparam int IQ_RS2_LO = 40;
    localparam int IQ_R1RE   = 38;
    localparam int IQ_R2RE   = 37;

    typedef logic [DEC_W-1:0] dec_inst_t;

    typedef enum logic [1:0] {
        IQJ_IDLE    = 2'd0,
        IQJ_EXEC    = 2'd1,
        IQJ_RESOLVE = 2'd2
    } iqj_state_t;

    // A source is ready when it is not read, is x0, or has no pending write.
    function automatic logic operands_ready(input dec_inst_t inst, input logic [31:0] busy);
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ok1;
        logic       ok2;
        rs1 = inst[IQ_RS1_HI:IQ_RS1_LO];
        rs2 = inst[IQ_RS2_HI:IQ_RS2_LO];
        ok1 = !inst[IQ_R1RE] || (rs1 == 5'd0) || !busy[rs1];
        ok2 = !inst[IQ_R2RE] || (rs2 == 5'd0) || !busy[rs2];
        return ok1 && ok2;
    endfunction

endpackage

// File: rtl/iq_jump_if.sv
// Dispatch, scoreboard, issue and resolution signals of the jump issue queue.
// Latency: none (wiring only).
// Backpressure: dispatch_ready_o throttles the dispatch side.
interface iq_jump_if #(
    parameter int DEPTH = 4
);
    import iq_jump_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             dispatch_en_i;
    logic [31:0]      dispatch_addr_i;
    dec_inst_t        dispatch_inst_i;
    logic             dispatch_ready_o;
    logic [31:0]      reg_busy_i;
    logic             iq_jump_0_en_o;
    logic [31:0]      iq_jump_0_addr_o;
    dec_inst_t        iq_jump_0_inst_o;
    logic             jump_flag_i;
    logic             jump_continue_i;
    logic [CNT_W-1:0] count_o;

    // Dispatch/execute side: drives the queue's inputs.
    modport master (
        output dispatch_en_i, dispatch_addr_i, dispatch_inst_i, reg_busy_i,
               jump_flag_i, jump_continue_i,
        input  dispatch_ready_o, iq_jump_0_en_o, iq_jump_0_addr_o,
               iq_jump_0_inst_o, count_o
    );

    // The queue itself.
    modport slave (
        input  dispatch_en_i, dispatch_addr_i, dispatch_inst_i, reg_busy_i,
               jump_flag_i, jump_continue_i,
        output dispatch_ready_o, iq_jump_0_en_o, iq_jump_0_addr_o,
               iq_jump_0_inst_o, count_o
    );

endinterface

// File: rtl/iq_jump_fifo.sv
// Circular storage of {PC, decoded word} with occupancy count and single-cycle flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when count==DEPTH nor pop when empty; flush overrides both.
module iq_jump_fifo
    import iq_jump_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_addr,
    input  dec_inst_t        push_inst,
    input  logic             pop,
    output logic [31:0]      head_addr,
    output dec_inst_t        head_inst,
    output logic [CNT_W-1:0] count
);

    logic [31:0]      addr_mem [DEPTH];
    dec_inst_t        inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_addr = addr_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

    // Payload write at the write pointer; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            addr_mem[wr_ptr] <= push_addr;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iq_jump.sv
// In-order jump issue queue: holds dispatched jumps until operands are free, issues one at a time.
// Latency: dispatch N -> issue strobe N+2 (N+1 via empty-queue bypass when IQ_JUMP_BYPASS_EN is defined); 3-cycle issue spacing.
// Backpressure: dispatch_ready_o low while count==DEPTH; jump_flag_i flushes the queue and drops same-cycle dispatch.
module iq_jump
    import iq_jump_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    iq_jump_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    iqj_state_t       state_q;
    iqj_state_t       state_d;
    logic [CNT_W-1:0] count;
    logic [31:0]      head_addr;
    dec_inst_t        head_inst;
    logic             head_vld;
    logic             head_rdy;
    logic             disp_rdy;
    logic             disp_ok;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             issue_en_q;
    logic [31:0]      issue_addr_q;
    dec_inst_t        issue_inst_q;
    logic             unused_continue;

    // Not-taken resolution carries no extra work: RESOLVE always returns to IDLE.
    assign unused_continue = bus.jump_continue_i;

    assign disp_rdy = count < CNT_W'(DEPTH);
    assign disp_ok  = bus.dispatch_en_i && disp_rdy && !bus.jump_flag_i;
    assign head_vld = count != '0;
    assign head_rdy = operands_ready(head_inst, bus.reg_busy_i);
    assign push     = disp_ok && !bypass;

    iq_jump_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.jump_flag_i),
        .push      (push),
        .push_addr (bus.dispatch_addr_i),
        .push_inst (bus.dispatch_inst_i),
        .pop       (pop),
        .head_addr (head_addr),
        .head_inst (head_inst),
        .count     (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IQJ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue decision in IDLE, then fixed EXEC/RESOLVE walk; a taken jump forces IDLE with no issue.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            IQJ_IDLE: begin
                if (head_vld && head_rdy) begin
                    pop = 1'b1;
                end
`ifdef IQ_JUMP_BYPASS_EN
                else if (!head_vld && disp_ok &&
                         operands_ready(bus.dispatch_inst_i, bus.reg_busy_i)) begin
                    bypass = 1'b1;
                end
`endif
                if (pop || bypass) begin
                    state_d = IQJ_EXEC;
                end
            end
            IQJ_EXEC:    state_d = IQJ_RESOLVE;
            IQJ_RESOLVE: state_d = IQJ_IDLE;
            default:     state_d = IQJ_IDLE;
        endcase
        if (bus.jump_flag_i) begin
            state_d = IQJ_IDLE;
            pop     = 1'b0;
            bypass  = 1'b0;
        end
    end

    // Issue registers: one-cycle strobe, payload holds until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_en_q   <= 1'b0;
            issue_addr_q <= '0;
            issue_inst_q <= '0;
        end else begin
            issue_en_q <= pop || bypass;
            if (pop) begin
                issue_addr_q <= head_addr;
                issue_inst_q <= head_inst;
            end else if (bypass) begin
                issue_addr_q <= bus.dispatch_addr_i;
                issue_inst_q <= bus.dispatch_inst_i;
            end
        end
    end

    assign bus.dispatch_ready_o = disp_rdy;
    assign bus.iq_jump_0_en_o   = issue_en_q;
    assign bus.iq_jump_0_addr_o = issue_addr_q;
    assign bus.iq_jump_0_inst_o = issue_inst_q;
    assign bus.count_o          = count;

endmodule

// File: tb/tb_iq_jump.sv
// Self-checking bench for iq_jump: directed scenarios plus random traffic against a queue/timestamp model.
// Latency: model expects issue one cycle after the decision, decisions at most every 3 cycles.
// Backpressure: model accepts dispatch only while it holds fewer than DEPTH entries.
module tb_iq_jump;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [71:0] w;
    } ent_t;

    logic clk;
    logic rst;

    iq_jump_if #(.DEPTH(DEPTH)) bus ();

    iq_jump #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          next_ok = 0;
    ent_t        q[$];
    logic        exp_en   = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [71:0] exp_inst = '0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Source-register readiness straight from the scoreboard rule.
    function automatic bit ops_ok(input logic [71:0] w, input logic [31:0] busy);
        int a;
        int b;
        a = int'(w[49:45]);
        b = int'(w[44:40]);
        if (w[38] && a != 0 && busy[a]) return 1'b0;
        if (w[37] && b != 0 && busy[b]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [71:0] mk_inst(input int rs1, input int rs2, input bit re1, input bit re2);
        logic [71:0] w;
        w = {8'($urandom), $urandom, $urandom};
        w[49:45] = 5'(rs1);
        w[44:40] = 5'(rs2);
        w[38]    = re1;
        w[37]    = re2;
        return w;
    endfunction

    // Advance the model by the current cycle's inputs, clock the DUT, compare all outputs.
    task automatic step();
        bit   acc;
        ent_t e;
        acc = 1'b0;
        if (rst) begin
            q.delete();
            exp_en   = 1'b0;
            exp_addr = '0;
            exp_inst = '0;
            next_ok  = cyc + 1;
        end else if (bus.jump_flag_i) begin
            q.delete();
            exp_en  = 1'b0;
            next_ok = cyc + 1;
        end else begin
            exp_en = 1'b0;
            acc = bus.dispatch_en_i && (q.size() < DEPTH);
            if (cyc >= next_ok) begin
                if (q.size() != 0) begin
                    if (ops_ok(q[0].w, bus.reg_busy_i)) begin
                        e = q.pop_front();
                        exp_en   = 1'b1;
                        exp_addr = e.a;
                        exp_inst = e.w;
                        next_ok  = cyc + 3;
                    end
                end
`ifdef IQ_JUMP_BYPASS_EN
                else if (acc && ops_ok(bus.dispatch_inst_i, bus.reg_busy_i)) begin
                    exp_en   = 1'b1;
                    exp_addr = bus.dispatch_addr_i;
                    exp_inst = bus.dispatch_inst_i;
                    next_ok  = cyc + 3;
                    acc      = 1'b0;
                end
`endif
            end
            if (acc) begin
                q.push_back('{a: bus.dispatch_addr_i, w: bus.dispatch_inst_i});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("en",    72'(bus.iq_jump_0_en_o),   72'(exp_en));
        check_eq("addr",  72'(bus.iq_jump_0_addr_o), 72'(exp_addr));
        check_eq("inst",  bus.iq_jump_0_inst_o,      exp_inst);
        check_eq("count", 72'(bus.count_o),          72'(q.size()));
        check_eq("ready", 72'(bus.dispatch_ready_o), 72'(q.size() < DEPTH));
    endtask

    task automatic idle_inputs();
        bus.dispatch_en_i   = 1'b0;
        bus.jump_flag_i     = 1'b0;
        bus.jump_continue_i = 1'b0;
        rst                 = 1'b0;
    endtask

    task automatic offer(input logic [31:0] a, input logic [71:0] w);
        bus.dispatch_en_i   = 1'b1;
        bus.dispatch_addr_i = a;
        bus.dispatch_inst_i = w;
    endtask

    logic [71:0] w0;

    initial begin
        bus.dispatch_en_i   = 1'b0;
        bus.dispatch_addr_i = '0;
        bus.dispatch_inst_i = '0;
        bus.reg_busy_i      = '0;
        bus.jump_flag_i     = 1'b0;
        bus.jump_continue_i = 1'b0;
        rst = 1'b1;
        #2;
        step();
        step();
        check_eq("rst_en",    72'(bus.iq_jump_0_en_o),   72'(0));
        check_eq("rst_count", 72'(bus.count_o),          72'(0));
        check_eq("rst_addr",  72'(bus.iq_jump_0_addr_o), 72'(0));
        idle_inputs();

        // 1: JAL with no source reads issues with the documented latency.
        w0 = mk_inst(0, 0, 1'b0, 1'b0);
        offer(32'h100, w0);
        step();
        idle_inputs();
`ifndef IQ_JUMP_BYPASS_EN
        step();
`endif
        check_eq("t1_en",   72'(bus.iq_jump_0_en_o),   72'(1));
        check_eq("t1_addr", 72'(bus.iq_jump_0_addr_o), 72'(32'h100));
        check_eq("t1_inst", bus.iq_jump_0_inst_o,      w0);
        repeat (3) step();
        check_eq("t1_count", 72'(bus.count_o), 72'(0));

        // 2: BEQ blocked on busy rs1=5 for 4 cycles, issues right after it clears.
        bus.reg_busy_i = 32'h20;
        offer(32'h200, mk_inst(5, 0, 1'b1, 1'b0));
        step();
        idle_inputs();
        repeat (4) step();
        check_eq("t2_held", 72'(bus.iq_jump_0_en_o), 72'(0));
        bus.reg_busy_i = '0;
        step();
        check_eq("t2_issue", 72'(bus.iq_jump_0_en_o), 72'(1));
        repeat (3) step();

        // 3: five back-to-back offers while everything is blocked; fifth refused, then in-order drain.
        bus.reg_busy_i = '1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h300 + 32'(4 * i), mk_inst(i + 1, 0, 1'b1, 1'b0));
            step();
            if (i == 3) check_eq("t3_full", 72'(bus.dispatch_ready_o), 72'(0));
        end
        idle_inputs();
        bus.reg_busy_i = '0;
        repeat (15) step();

        // 4: flush during RESOLVE with a same-cycle dispatch.
        for (int i = 0; i < 30; i++) begin
            if (q.size() >= 2 && cyc == next_ok - 1) break;
            offer(32'h400 + 32'(4 * i), mk_inst(0, 0, 1'b0, 1'b0));
            step();
        end
        bus.jump_flag_i = 1'b1;
        offer(32'h4F0, mk_inst(0, 0, 1'b0, 1'b0));
        step();
        idle_inputs();
        check_eq("t4_count", 72'(bus.count_o), 72'(0));
        repeat (6) step();

        // 5: fill and drain ten times to exercise pointer wrap.
        for (int r = 0; r < 10; r++) begin
            bus.reg_busy_i = '1;
            for (int i = 0; i < DEPTH; i++) begin
                offer($urandom, mk_inst($urandom_range(31, 1), 0, 1'b1, 1'b0));
                step();
            end
            idle_inputs();
            bus.reg_busy_i = '0;
            repeat (14) step();
        end

        // 6: reset while EXEC with a dispatch pending.
        offer(32'h600, mk_inst(0, 0, 1'b0, 1'b0));
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            if (exp_en) break;
            step();
        end
        rst = 1'b1;
        offer(32'h604, mk_inst(0, 0, 1'b0, 1'b0));
        step();
        idle_inputs();
        check_eq("t6_en",    72'(bus.iq_jump_0_en_o), 72'(0));
        check_eq("t6_count", 72'(bus.count_o),        72'(0));
        step();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            bus.reg_busy_i      = $urandom & $urandom;
            bus.dispatch_en_i   = ($urandom_range(1, 0) == 1);
            bus.dispatch_addr_i = $urandom;
            bus.dispatch_inst_i = mk_inst($urandom_range(31, 0), $urandom_range(31, 0),
                                          1'($urandom), 1'($urandom));
            bus.jump_flag_i     = ($urandom_range(29, 0) == 0);
            bus.jump_continue_i = 1'($urandom);
            rst                 = ($urandom_range(299, 0) == 0);
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
